// File: rtl/seq_intt.sv
`timescale 1ns/1ps
// Sequential inverse NTT: one multiply-accumulate term per cycle, then a
// per-output scale by N^-1; the result bus fills in progressively.
module seq_intt #(
  parameter int unsigned N     = 17,
  parameter int unsigned D     = 8,
  parameter int unsigned Q     = 137,
  parameter int unsigned W_INV = 38,
  parameter int unsigned N_INV = 129
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [D*N-1:0] an,
  output logic           busy,
  output logic           done,
  output logic [D*N-1:0] a
);

  localparam int unsigned PW = 2 * D;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SCALE, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [D-1:0]  r_acc;
  logic [D-1:0]  r_tw;
  logic [D-1:0]  r_step;
  logic [D-1:0]  r_in  [N];
  logic [D-1:0]  r_res [N];
  logic          r_busy;
  logic          r_done;

  logic [D-1:0]  w_ai;
  logic [D-1:0]  w_acc_nxt;
  logic [D-1:0]  w_tw_nxt;
  logic [D-1:0]  w_step_nxt;
  logic [D-1:0]  w_scaled;
  logic [PW:0]   w_mac_sum;
  logic [PW-1:0] w_tw_prod;
  logic [PW-1:0] w_step_prod;
  logic [PW-1:0] w_scale_prod;

  // Modular arithmetic; the sum is one bit wider so inputs >= Q still fold correctly
  always_comb begin
    w_ai         = r_in[r_i];
    w_mac_sum    = (PW+1)'(r_acc) + ((PW+1)'(w_ai) * (PW+1)'(r_tw));
    w_acc_nxt    = D'(w_mac_sum % (PW+1)'(Q));
    w_tw_prod    = PW'(r_tw) * PW'(r_step);
    w_tw_nxt     = D'(w_tw_prod % PW'(Q));
    w_step_prod  = PW'(r_step) * PW'(W_INV);
    w_step_nxt   = D'(w_step_prod % PW'(Q));
    w_scale_prod = PW'(r_acc) * PW'(N_INV);
    w_scaled     = D'(w_scale_prod % PW'(Q));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_MAC;
      S_MAC:   if (r_i == CW'(N - 1)) w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = (r_j == CW'(N - 1)) ? S_DONE : S_MAC;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_MAC) || (w_state_nxt == S_SCALE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i    <= '0;
      r_j    <= '0;
      r_acc  <= '0;
      r_tw   <= '0;
      r_step <= '0;
      for (int k = 0; k < int'(N); k++) begin
        r_in[k]  <= '0;
        r_res[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < int'(N); k++) r_in[k] <= an[D*k +: D];
            r_i    <= '0;
            r_j    <= '0;
            r_acc  <= '0;
            r_tw   <= D'(1);
            r_step <= D'(1);
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          r_tw  <= w_tw_nxt;
          r_i   <= r_i + CW'(1);
        end
        S_SCALE: begin
          r_res[r_j] <= w_scaled;
          r_step     <= w_step_nxt;
          r_acc      <= '0;
          r_tw       <= D'(1);
          r_i        <= '0;
          r_j        <= r_j + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  for (genvar g = 0; g < int'(N); g++) begin : g_out
    assign a[D*g +: D] = r_res[g];
  end

endmodule

// File: tb/tb_seq_intt.sv
`timescale 1ns/1ps
// Bench for seq_intt: expected result vectors are queued at start and
// compared coefficient by coefficient on every done pulse.
module tb_seq_intt;

  localparam int unsigned N    = 17;
  localparam int unsigned D    = 8;
  localparam int unsigned Q    = 137;
  localparam int unsigned ROOT = 119;
  localparam int unsigned BW   = D * N;
  localparam int unsigned LAT  = N * (N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] an;
  logic          busy;
  logic          done;
  logic [BW-1:0] a;

  int n_vec   = 0;
  int n_err   = 0;
  int n_done  = 0;
  int cyc     = 0;
  int t_start = 0;

  logic [BW-1:0] sb_q[$];

  seq_intt #(.N(N), .D(D), .Q(Q), .W_INV(38), .N_INV(129)) dut (
    .clk(clk), .rst(rst), .start(start), .an(an),
    .busy(busy), .done(done), .a(a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] fill(input int unsigned val);
    logic [BW-1:0] v;
    for (int k = 0; k < int'(N); k++) v[D*k +: D] = D'(val);
    return v;
  endfunction

  function automatic int unsigned powmod(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int k = 0; k < int'(e); k++) r = (r * b) % Q;
    return r;
  endfunction

  // Reference forward transform with the primitive root 119
  function automatic logic [BW-1:0] fwd_ntt(input logic [BW-1:0] c);
    logic [BW-1:0] r;
    int unsigned   s;
    for (int i = 0; i < int'(N); i++) begin
      s = 0;
      for (int j = 0; j < int'(N); j++)
        s = (s + 32'(c[D*j +: D]) * powmod(ROOT, 32'((i * j) % int'(N)))) % Q;
      r[D*i +: D] = D'(s);
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_coefs();
    logic [BW-1:0] v;
    for (int k = 0; k < int'(N); k++) v[D*k +: D] = D'($urandom_range(0, Q - 1));
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int k = 0; k < int'(N); k++) v[D*k +: D] = D'($urandom_range(0, 255));
    return v;
  endfunction

  // One transform: queue the expectation, start, optionally disturb the inputs, await done
  task automatic run(input logic [BW-1:0] vec, input logic [BW-1:0] expv,
                     input bit hold, input bit scramble);
    bit seen;
    @(negedge clk);
    an    = vec;
    start = 1'b1;
    sb_q.push_back(expv);
    @(posedge clk);
    #1;
    t_start = cyc;
    if (!hold) start = 1'b0;
    if (scramble) an = rand_bus();
    chk("busy_rise", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (hold) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin : mon
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("busy_with_done", 32'(busy), 32'd0);
        chk("latency", 32'(cyc - t_start), 32'(LAT));
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          for (int k = 0; k < int'(N); k++)
            chk($sformatf("a[%0d]", k), 32'(a[D*k +: D]), 32'(e[D*k +: D]));
        end
      end
    end
  end

  initial begin : stim
    logic [BW-1:0] delta;
    logic [BW-1:0] c;
    logic [BW-1:0] av;
    int            snap;

    delta = '0;
    delta[D-1:0] = D'(1);
    rst   = 1'b1;
    start = 1'b0;
    an    = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_a", 32'(|a), 32'd0);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_a", 32'(|a), 32'd0);
    chk("idle_no_done", 32'(n_done), 32'd0);

    run(delta, fill(129), 1'b0, 1'b0);

    // Asynchronous clear observed between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_a", 32'(|a), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_a", 32'(|a), 32'd0);

    c = '0;
    c[D-1:0] = D'(5);
    run(fill(5), c, 1'b0, 1'b0);
    run(fill(142), c, 1'b0, 1'b0);

    run(delta, fill(129), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("held_start_idle", 32'(busy), 32'd0);
    end

    c = rand_coefs();
    run(fwd_ntt(c), c, 1'b0, 1'b1);

    for (int v = 0; v < 100; v++) begin
      c  = rand_coefs();
      av = fwd_ntt(c);
      for (int k = 0; k < int'(N); k++)
        if (av[D*k +: D] < 8'd119 && $urandom_range(0, 3) == 0)
          av[D*k +: D] = av[D*k +: D] + D'(Q);
      run(av, c, 1'b0, 1'b0);
    end

    // Abort in the middle of a run: no done, result cleared
    snap = n_done;
    @(negedge clk);
    an    = delta;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_a", 32'(|a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (320) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'(snap));
    chk("abort_a_held", 32'(|a), 32'd0);

    run(delta, fill(129), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
